mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
Sequencer for the shift-add signed multiplier datapath. The datapath is the 1-bit sign register X, the 8-bit accumulator A, the multiplier register B and the 9-bit add/subtract adder. The block issues the clear, load and shift strobes and the Sub select for one full Booth-free two's-complement multiply per Run press. It sits between the synchronized button inputs and the register/adder instances in the multiplier top level, and adds Busy, Done and bit-count status for simulation and LEDs.

Parameters:
WIDTH, 8, operand width; number of add/shift iterations.
CLR_ON_RUN, 1, 1: clear A and X in a START cycle before iterating; 0: skip START and accumulate onto the current A.
CW, $clog2(WIDTH+1), width of BitCnt (derived; do not override).

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
ClearA_LoadB  in  1  synchronized level; clear A/X and load B from switches
Run  in  1  synchronized level; start multiply
M  in  1  current multiplier LSB (B[0])
ClrX, LdX, ShX  out  1 each  X register strobes
ClrA, LdA, ShA  out  1 each  A register strobes
ClrB, LdB, ShB  out  1 each  B register strobes
Sub  out  1  adder subtract select (invert B operand, carry-in 1)
Busy  out  1  high from START/first ADD through final SHIFT
Done  out  1  one-cycle pulse after final SHIFT
BitCnt  out  CW  iterations completed, 0..WIDTH

Behaviour:
- States: IDLE, START, ADD, SHIFT, DONE, HOLD. Registers: state and BitCnt.
- Reset has priority over all other inputs. While Reset=1:
  - ClrX=ClrA=ClrB=1; every other strobe, Sub, Busy and Done are 0.
  - Next state is IDLE and BitCnt<=0.
  - A Reset mid-multiply aborts immediately, with no Done pulse.
- IDLE:
  - Run=1 -> START if CLR_ON_RUN=1, else ADD. BitCnt<=0.
  - Run=0 and ClearA_LoadB=1 -> assert ClrA, ClrX and LdB in that cycle. Repeated every cycle while held; stay in IDLE.
  - Run has priority over ClearA_LoadB in the same cycle.
- START: ClrA=ClrX=1 for exactly one cycle -> ADD.
- ADD (Mealy on M):
  - M=1: LdA=LdX=1.
  - M=0: no strobes.
  - Sub=1 iff BitCnt==WIDTH-1, independent of M, so the last partial product is subtracted (sign of multiplier). Sub=0 in every other state.
  - Next state: SHIFT.
- SHIFT: ShX=ShA=ShB=1; BitCnt<=BitCnt+1.
  - New BitCnt==WIDTH -> DONE.
  - Otherwise -> ADD.
- DONE: Done=1 for one cycle; no strobes -> HOLD.
- HOLD: no strobes; wait until Run=0 -> IDLE. A held Run starts exactly one multiply. ClearA_LoadB is ignored.
- Busy=1 in START, ADD and SHIFT only.
- Latency from the Run-sampled edge to the Done pulse:
  - CLR_ON_RUN=1: 2*WIDTH+2 cycles (1 START + WIDTH ADD/SHIFT pairs + DONE).
  - CLR_ON_RUN=0: 2*WIDTH+1 cycles.
- Run and ClearA_LoadB are ignored while Busy. M is sampled only in ADD.
- Never assert a load and a shift on the same register in the same cycle. Never assert Clr together with Ld/Sh except during Reset.
- BitCnt holds WIDTH through DONE and HOLD. It returns to 0 only on the next start or on Reset.

Test Plan:
- Reset, then IDLE with Run=0 and ClearA_LoadB=0 -> every strobe, Busy and Done are 0; BitCnt=0. Assert Reset for 1 cycle mid-ADD -> IDLE next cycle with no Done pulse.
- Against the real datapath: ClearA_LoadB with S=0x03 (B=3), then Run with S=0x07 -> Done pulses 18 cycles after Run is sampled; A:B=0x0015; X=0.
- B=0xFF, S=0xFF (-1×-1) -> A:B=0x0001. Sub=1 only in the 8th ADD cycle; LdA is pulsed 8 times.
- B=0x00, S=0x5A -> LdA never asserted; 8 ShA/ShB pulses; A:B=0x0000. B=0x80, S=0x02 -> A:B=0xFF00 (-256); Sub with LdA in the last ADD.
- Hold Run high for 100 cycles -> exactly one Done pulse. Release then re-press -> a second multiply; with CLR_ON_RUN=1 the result equals the first.
- Pulse ClearA_LoadB while Busy -> no ClrA/LdB issued; the result is unaffected. ClearA_LoadB and Run high together in IDLE -> START entered; no LdB.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Control sequencer for the X/A/B shift-add two's-complement multiplier.
// One multiply per Run press: optional clear, WIDTH add/shift pairs, Done pulse.
module mult_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit CLR_ON_RUN = 1'b1,
    parameter int CW         = $clog2(WIDTH + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          ClearA_LoadB,
    input  logic          Run,
    input  logic          M,
    output logic          ClrX,
    output logic          LdX,
    output logic          ShX,
    output logic          ClrA,
    output logic          LdA,
    output logic          ShA,
    output logic          ClrB,
    output logic          LdB,
    output logic          ShB,
    output logic          Sub,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] BitCnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4,
        HOLD  = 3'd5
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt_nxt;

    always_ff @(posedge Clk) begin
        state  <= state_nxt;
        BitCnt <= cnt_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = BitCnt;
        ClrX = 1'b0; LdX = 1'b0; ShX = 1'b0;
        ClrA = 1'b0; LdA = 1'b0; ShA = 1'b0;
        ClrB = 1'b0; LdB = 1'b0; ShB = 1'b0;
        Sub  = 1'b0;
        Busy = 1'b0;
        Done = 1'b0;

        if (Reset) begin
            ClrX      = 1'b1;
            ClrA      = 1'b1;
            ClrB      = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Run wins over ClearA_LoadB so a simultaneous press never reloads B.
                    if (Run) begin
                        state_nxt = CLR_ON_RUN ? START : ADD;
                        cnt_nxt   = '0;
                    end else if (ClearA_LoadB) begin
                        ClrA = 1'b1;
                        ClrX = 1'b1;
                        LdB  = 1'b1;
                    end
                end
                START: begin
                    Busy      = 1'b1;
                    ClrA      = 1'b1;
                    ClrX      = 1'b1;
                    state_nxt = ADD;
                end
                ADD: begin
                    Busy      = 1'b1;
                    LdA       = M;
                    LdX       = M;
                    // The multiplier's MSB carries negative weight: subtract its partial product.
                    Sub       = (BitCnt == CNT_LAST);
                    state_nxt = SHIFT;
                end
                SHIFT: begin
                    Busy      = 1'b1;
                    ShX       = 1'b1;
                    ShA       = 1'b1;
                    ShB       = 1'b1;
                    cnt_nxt   = BitCnt + 1'b1;
                    state_nxt = (cnt_nxt == CNT_FULL) ? DONE : ADD;
                end
                DONE: begin
                    Done      = 1'b1;
                    state_nxt = HOLD;
                end
                HOLD: begin
                    if (!Run)
                        state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: drives a behavioural X/A/B datapath from the strobes and
// checks every cycle against a slot-sequence model plus signed-product results.
module tb_mult_seq_ctrl;
    localparam int W   = 8;
    localparam int CW  = $clog2(W + 1);
    localparam bit CLR = 1'b1;
    localparam int L   = (CLR ? 1 : 0) + 2 * W + 1;

    logic          Clk = 1'b0;
    logic          Reset, ClearA_LoadB, Run, M;
    logic          ClrX, LdX, ShX, ClrA, LdA, ShA, ClrB, LdB, ShB, Sub, Busy, Done;
    logic [CW-1:0] BitCnt;
    logic [11:0]   vec;
    logic [7:0]    S, dp_A, dp_B;
    logic          dp_X;
    bit            armed = 1'b0;

    int n_chk = 0, n_fail = 0;
    int c_done, c_lda, c_sub, c_sha, c_shb, c_ldb, c_sublda;

    mult_seq_ctrl #(.WIDTH(W), .CLR_ON_RUN(CLR)) dut (
        .Clk(Clk), .Reset(Reset), .ClearA_LoadB(ClearA_LoadB), .Run(Run), .M(M),
        .ClrX(ClrX), .LdX(LdX), .ShX(ShX), .ClrA(ClrA), .LdA(LdA), .ShA(ShA),
        .ClrB(ClrB), .LdB(LdB), .ShB(ShB), .Sub(Sub), .Busy(Busy), .Done(Done),
        .BitCnt(BitCnt)
    );

    always #5 Clk = ~Clk;

    assign vec = {ClrX, LdX, ShX, ClrA, LdA, ShA, ClrB, LdB, ShB, Sub, Busy, Done};
    assign M   = dp_B[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Datapath stand-in: 9-bit sign-extended add/sub, arithmetic shift of X:A:B.
    always @(posedge Clk) begin
        logic [8:0] sum;
        sum = {dp_A[7], dp_A} + (Sub ? (~{S[7], S} + 9'd1) : {S[7], S});
        if (ClrX)     dp_X <= 1'b0;
        else if (LdX) dp_X <= sum[8];
        if (ClrA)     dp_A <= 8'h00;
        else if (LdA) dp_A <= sum[7:0];
        else if (ShA) dp_A <= {dp_X, dp_A[7:1]};
        if (ClrB)     dp_B <= 8'h00;
        else if (LdB) dp_B <= S;
        else if (ShB) dp_B <= {dp_A[0], dp_B[7:1]};
    end

    // Model: 0 = idle, 1 = walking the fixed slot list, 2 = waiting for Run release.
    int         mode = 0, pos = 0, cnt = 0;
    logic [7:0] b0, s0;

    always @(negedge Clk) if (armed) begin
        logic [11:0] e;
        int          off, pr;
        bit          is_shift;
        e        = '0;
        is_shift = 1'b0;
        if (Reset) begin
            e[11] = 1'b1; e[8] = 1'b1; e[5] = 1'b1;
        end else if (mode == 0) begin
            if (!Run && ClearA_LoadB) begin
                e[11] = 1'b1; e[8] = 1'b1; e[4] = 1'b1;
            end
        end else if (mode == 1) begin
            off = pos - (CLR ? 1 : 0);
            if (off < 0) begin
                e[11] = 1'b1; e[8] = 1'b1; e[1] = 1'b1;
            end else if (off == 2 * W) begin
                e[0] = 1'b1;
                pr = int'($signed(b0)) * int'($signed(s0));
                chk("product", {dp_A, dp_B}, pr[15:0]);
            end else if (off % 2 == 0) begin
                e[1] = 1'b1; e[10] = M; e[7] = M;
                e[2] = (off / 2 == W - 1);
            end else begin
                e[9] = 1'b1; e[6] = 1'b1; e[3] = 1'b1; e[1] = 1'b1;
                is_shift = 1'b1;
            end
        end
        chk("strobes", vec, e);
        chk("BitCnt", BitCnt, cnt);

        c_done   += Done;
        c_lda    += LdA;
        c_sub    += Sub;
        c_sha    += ShA;
        c_shb    += ShB;
        c_ldb    += LdB;
        c_sublda += (Sub && LdA);

        if (Reset) begin
            mode = 0; cnt = 0;
        end else if (mode == 0) begin
            if (Run) begin
                mode = 1; pos = 0; cnt = 0; b0 = dp_B; s0 = S;
            end
        end else if (mode == 1) begin
            if (is_shift) cnt++;
            pos++;
            if (pos == L) mode = 2;
        end else if (!Run) begin
            mode = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic clr_counts();
        c_done = 0; c_lda = 0; c_sub = 0; c_sha = 0; c_shb = 0; c_ldb = 0; c_sublda = 0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (edges < 200) begin
            tick(1);
            edges++;
            if (Done) break;
        end
        if (edges >= 200) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic load_b(input logic [7:0] b);
        S = b; ClearA_LoadB = 1'b1;
        tick(1);
        ClearA_LoadB = 1'b0;
        tick(1);
    endtask

    task automatic mult(input logic [7:0] s, output int lat);
        S = s; clr_counts(); Run = 1'b1;
        wait_done(lat);
        Run = 1'b0;
        tick(2);
    endtask

    initial begin
        int lat, hold, rst_at, guard;
        bit do_rst;
        Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; S = 8'h00;
        @(posedge Clk);
        armed = 1'b1;
        tick(2);
        Reset = 1'b0;
        tick(2);
        chk("idle_quiet", vec, 12'h000);
        chk("idle_cnt", BitCnt, 0);

        load_b(8'h03); mult(8'h07, lat);
        chk("lat_3x7", lat, 18);
        chk("res_3x7", {dp_A, dp_B}, 16'h0015);
        chk("x_3x7", dp_X, 1'b0);
        chk("cnt_hold", BitCnt, W);

        load_b(8'hFF); mult(8'hFF, lat);
        chk("res_m1xm1", {dp_A, dp_B}, 16'h0001);
        chk("sub_count", c_sub, 1);
        chk("lda_count", c_lda, 8);

        load_b(8'h00); mult(8'h5A, lat);
        chk("lda_zero", c_lda, 0);
        chk("sha_count", c_sha, 8);
        chk("shb_count", c_shb, 8);
        chk("res_zero", {dp_A, dp_B}, 16'h0000);

        load_b(8'h80); mult(8'h02, lat);
        chk("res_neg", {dp_A, dp_B}, 16'hFF00);
        chk("sub_with_lda", c_sublda, 1);

        load_b(8'h01); S = 8'h01; clr_counts(); Run = 1'b1;
        tick(100);
        Run = 1'b0; tick(2);
        chk("one_done", c_done, 1);
        chk("res_hold1", {dp_A, dp_B}, 16'h0001);
        mult(8'h01, lat);
        chk("res_hold2", {dp_A, dp_B}, 16'h0001);

        load_b(8'h03); S = 8'h07; clr_counts(); Run = 1'b1;
        tick(1); Run = 1'b0; tick(4);
        ClearA_LoadB = 1'b1; tick(2); ClearA_LoadB = 1'b0;
        wait_done(lat); tick(2);
        chk("busy_ldb", c_ldb, 0);
        chk("res_busy_cla", {dp_A, dp_B}, 16'h0015);

        S = 8'h33; clr_counts(); ClearA_LoadB = 1'b1; Run = 1'b1;
        tick(1);
        chk("both_busy", Busy, 1'b1);
        chk("both_ldb", c_ldb, 0);
        Run = 1'b0; ClearA_LoadB = 1'b0;
        wait_done(lat); tick(2);

        load_b(8'h05); Run = 1'b1; tick(1); Run = 1'b0; tick(3);
        chk("mid_add_busy", Busy, 1'b1);
        Reset = 1'b1; tick(1); Reset = 1'b0;
        chk("abort_busy", Busy, 1'b0);
        chk("abort_cnt", BitCnt, 0);
        clr_counts(); tick(30);
        chk("abort_nodone", c_done, 0);

        for (int it = 0; it < 40; it++) begin
            load_b(8'($urandom));
            S = 8'($urandom);
            hold   = $urandom_range(1, 25);
            do_rst = ($urandom % 8 == 0);
            rst_at = $urandom_range(2, 14);
            Run = 1'b1;
            for (int k = 0; k <= 40; k++) begin
                if (k == hold) Run = 1'b0;
                ClearA_LoadB = ($urandom % 4 == 0) && k > 1 && k < 15;
                Reset = do_rst && (k == rst_at);
                tick(1);
            end
            Run = 1'b0; ClearA_LoadB = 1'b0; Reset = 1'b0;
            guard = 0;
            while (Busy && guard < 40) begin tick(1); guard++; end
            if (guard >= 40) chk("rand_busy_timeout", 32'd0, 32'd1);
            tick(3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
